// File: rtl/int_queue_scheduler.sv
// Integer issue-queue scheduler.
// Tracks relative age of queue entries in an age matrix and, each cycle,
// selects the oldest entry whose operands are ready into a single registered
// issue slot. The slot is released to the queue owner when the ALU accepts it.
module int_queue_scheduler #(
    parameter int QSIZE = 8,
    parameter int QIDX  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             alloc0_valid,
    input  logic [QIDX-1:0]  alloc0_idx,
    input  logic             alloc1_valid,
    input  logic [QIDX-1:0]  alloc1_idx,
    input  logic [QSIZE-1:0] entry_valid,
    input  logic [QSIZE-1:0] entry_ready,
    output logic             issue_valid,
    output logic [QIDX-1:0]  issue_idx,
    input  logic             alu_ready,
    output logic             free_valid,
    output logic [QIDX-1:0]  free_idx
);

    // Converts a one-hot vector to its index; the input is unique by
    // construction, so OR-ing the matching indices is sufficient.
    function automatic logic [QIDX-1:0] onehot_to_idx(input logic [QSIZE-1:0] oh);
        logic [QIDX-1:0] idx;
        idx = {QIDX{1'b0}};
        for (int k = 0; k < QSIZE; k++) begin
            if (oh[k]) begin
                idx = idx | QIDX'(k);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // age_r[i][j] = 1 means entry i is older than entry j
    logic [QSIZE-1:0] age_r [QSIZE];
    logic [QSIZE-1:0] age_s [QSIZE];

    logic             issue_valid_r;
    logic [QIDX-1:0]  issue_idx_r;
    logic             issue_valid_s;
    logic [QIDX-1:0]  issue_idx_s;

    logic [QSIZE-1:0] held_s;
    logic [QSIZE-1:0] cand_s;
    logic [QSIZE-1:0] sel_oh_s;
    logic [QIDX-1:0]  sel_idx_s;
    logic             sel_any_s;

    // Age matrix update for new allocations: a new entry's row is cleared and
    // its column is set for every entry already occupied. alloc1 is applied
    // after alloc0, so alloc0's entry counts as older than alloc1's.
    always_comb begin
        age_s = age_r;
        for (int i = 0; i < QSIZE; i++) begin
            for (int j = 0; j < QSIZE; j++) begin
                if (alloc1_valid && (alloc1_idx == QIDX'(i))) begin
                    age_s[i][j] = 1'b0;
                end else if (alloc1_valid && (alloc1_idx == QIDX'(j)) &&
                             (entry_valid[i] || (alloc0_valid && (alloc0_idx == QIDX'(i))))) begin
                    age_s[i][j] = 1'b1;
                end else if (alloc0_valid && (alloc0_idx == QIDX'(i))) begin
                    age_s[i][j] = 1'b0;
                end else if (alloc0_valid && (alloc0_idx == QIDX'(j)) && entry_valid[i]) begin
                    age_s[i][j] = 1'b1;
                end else begin
                    age_s[i][j] = age_r[i][j];
                end
            end
        end
    end

    // Mask of the entry currently parked in the issue slot; it must not be
    // re-selected while it sits there, even in the cycle it is accepted.
    always_comb begin
        held_s = {QSIZE{1'b0}};
        if (issue_valid_r) begin
            held_s[issue_idx_r] = 1'b1;
        end else begin
            held_s = {QSIZE{1'b0}};
        end
    end

    // Oldest-ready selection: a candidate wins when no other candidate is
    // marked older than it in the age matrix.
    always_comb begin
        cand_s   = entry_valid & entry_ready & ~held_s;
        sel_oh_s = {QSIZE{1'b0}};
        for (int i = 0; i < QSIZE; i++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < QSIZE; j++) begin
                blocked = blocked | (cand_s[j] & age_r[j][i]);
            end
            sel_oh_s[i] = cand_s[i] & ~blocked;
        end
        sel_any_s = |sel_oh_s;
        sel_idx_s = onehot_to_idx(sel_oh_s);
    end

    // Issue slot next state: squash on flush, refill when empty or being
    // accepted, drain when accepted with nothing to replace it, else hold.
    always_comb begin
        issue_valid_s = issue_valid_r;
        issue_idx_s   = issue_idx_r;
        if (flush) begin
            issue_valid_s = 1'b0;
        end else if ((!issue_valid_r || alu_ready) && sel_any_s) begin
            issue_valid_s = 1'b1;
            issue_idx_s   = sel_idx_s;
        end else if (issue_valid_r && alu_ready) begin
            issue_valid_s = 1'b0;
        end else begin
            issue_valid_s = issue_valid_r;
            issue_idx_s   = issue_idx_r;
        end
    end

    // Age matrix register: cleared by reset and by flush (allocs ignored then).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < QSIZE; i++) begin
                age_r[i] <= {QSIZE{1'b0}};
            end
        end else if (flush) begin
            for (int i = 0; i < QSIZE; i++) begin
                age_r[i] <= {QSIZE{1'b0}};
            end
        end else begin
            age_r <= age_s;
        end
    end

    // Issue slot register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_valid_r <= 1'b0;
            issue_idx_r   <= {QIDX{1'b0}};
        end else begin
            issue_valid_r <= issue_valid_s;
            issue_idx_r   <= issue_idx_s;
        end
    end

    assign issue_valid = issue_valid_r;
    assign issue_idx   = issue_idx_r;
    // Release is combinational so the owner can free the entry in the same
    // cycle the ALU takes it; suppressed by flush and while in reset.
    assign free_valid  = issue_valid_r & alu_ready & ~flush & rst_n;
    assign free_idx    = issue_idx_r;

endmodule

// File: tb/tb_int_queue_scheduler.sv
// Testbench for int_queue_scheduler. The bench plays the queue owner:
// it tracks occupancy and allocation order, predicts each release and the
// issue-slot contents, and a monitor compares them against the DUT.
module tb_int_queue_scheduler;
    localparam int QSIZE = 8;
    localparam int QIDX  = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             alloc0_valid;
    logic [QIDX-1:0]  alloc0_idx;
    logic             alloc1_valid;
    logic [QIDX-1:0]  alloc1_idx;
    logic [QSIZE-1:0] entry_valid;
    logic [QSIZE-1:0] entry_ready;
    logic             issue_valid;
    logic [QIDX-1:0]  issue_idx;
    logic             alu_ready;
    logic             free_valid;
    logic [QIDX-1:0]  free_idx;

    always #5 clk = ~clk;

    int_queue_scheduler #(.QSIZE(QSIZE), .QIDX(QIDX)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc0_valid(alloc0_valid), .alloc0_idx(alloc0_idx),
        .alloc1_valid(alloc1_valid), .alloc1_idx(alloc1_idx),
        .entry_valid(entry_valid), .entry_ready(entry_ready),
        .issue_valid(issue_valid), .issue_idx(issue_idx),
        .alu_ready(alu_ready),
        .free_valid(free_valid), .free_idx(free_idx)
    );

    typedef struct { int cyc; int idx; } free_t;
    typedef struct { int cyc; bit v; int idx; } slot_t;
    free_t fq[$];
    slot_t sq[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    // reference model: owner occupancy, allocation sequence numbers, issue slot
    bit occ [QSIZE];
    int seqn[QSIZE];
    int seq_ctr = 0;
    bit m_v     = 1'b0;
    int m_idx   = 0;

    // Apply one cycle of stimulus, predict its outcome, advance one clock.
    task automatic step(input bit rstn_i, input bit flush_i,
                        input bit a0v, input int a0i,
                        input bit a1v, input int a1i,
                        input logic [QSIZE-1:0] rdy, input bit alu);
        bit fr;
        int best;
        assert (!(a0v && a1v && a0i == a1i)) else $error("alloc index collision %0d", a0i);
        rst_n        = rstn_i;
        flush        = flush_i;
        alloc0_valid = a0v;
        alloc0_idx   = QIDX'(a0i);
        alloc1_valid = a1v;
        alloc1_idx   = QIDX'(a1i);
        entry_ready  = rdy;
        alu_ready    = alu;
        for (int k = 0; k < QSIZE; k++) entry_valid[k] = occ[k];

        fr = rstn_i && !flush_i && m_v && alu;
        if (fr) fq.push_back('{cyc: cyc, idx: m_idx});

        if (!rstn_i || flush_i) begin
            m_v = 1'b0;
            if (!rstn_i) m_idx = 0;
            for (int k = 0; k < QSIZE; k++) occ[k] = 1'b0;
        end else begin
            best = -1;
            for (int k = 0; k < QSIZE; k++) begin
                if (occ[k] && rdy[k] && !(m_v && m_idx == k) &&
                    (best < 0 || seqn[k] < seqn[best])) best = k;
            end
            if (fr) occ[m_idx] = 1'b0;
            if ((!m_v || alu) && best >= 0) begin
                m_v   = 1'b1;
                m_idx = best;
            end else if (m_v && alu) begin
                m_v = 1'b0;
            end
            if (a0v) begin occ[a0i] = 1'b1; seqn[a0i] = seq_ctr; seq_ctr++; end
            if (a1v) begin occ[a1i] = 1'b1; seqn[a1i] = seq_ctr; seq_ctr++; end
        end
        sq.push_back('{cyc: cyc + 1, v: m_v, idx: m_idx});
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input bit alu);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 8'h00, alu);
    endtask

    // Monitor: on the falling edge, compare DUT releases and slot contents
    // with the predictions queued for this cycle.
    always @(negedge clk) begin
        while (fq.size() > 0 && fq[0].cyc < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL free_missing cyc %0d: free_valid=0, required free of idx %0d", fq[0].cyc, fq[0].idx);
            void'(fq.pop_front());
        end
        if (free_valid === 1'b1) begin
            vectors++;
            if (fq.size() > 0 && fq[0].cyc == cyc) begin
                if (free_idx !== QIDX'(fq[0].idx)) begin
                    miscompares++;
                    $display("FAIL free_idx cyc %0d: got %0d, required %0d", cyc, free_idx, fq[0].idx);
                end
                void'(fq.pop_front());
            end else begin
                miscompares++;
                $display("FAIL free_unexpected cyc %0d: got free_valid=1 idx %0d, required free_valid=0", cyc, free_idx);
            end
        end
        while (sq.size() > 0 && sq[0].cyc < cyc) void'(sq.pop_front());
        if (sq.size() > 0 && sq[0].cyc == cyc) begin
            vectors++;
            if (issue_valid !== sq[0].v || (sq[0].v && issue_idx !== QIDX'(sq[0].idx))) begin
                miscompares++;
                $display("FAIL issue_slot cyc %0d: got v=%0b idx=%0d, required v=%0b idx=%0d",
                         cyc, issue_valid, issue_idx, sq[0].v, sq[0].idx);
            end
            void'(sq.pop_front());
        end
    end

    initial begin
        int fl[$];
        int p;
        bit a0v, a1v, rs, fl_i, alu;
        int a0i, a1i;
        logic [QSIZE-1:0] rdy;

        for (int k = 0; k < QSIZE; k++) begin occ[k] = 1'b0; seqn[k] = 0; end
        rst_n = 1'b0; flush = 1'b0; alloc0_valid = 1'b0; alloc0_idx = '0;
        alloc1_valid = 1'b0; alloc1_idx = '0; entry_valid = '0; entry_ready = '0;
        alu_ready = 1'b0;
        @(posedge clk);
        #2;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 8'h00, 1'b0);

        // basic alloc -> ready -> issue -> free of entry 2
        step(1'b1, 1'b0, 1'b1, 2, 1'b0, 0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 8'h04, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 8'h04, 1'b1);
        idle(1'b1);

        // allocation order 5,1,3 issues back to back
        step(1'b1, 1'b0, 1'b1, 5, 1'b0, 0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1, 1'b0, 0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b1, 3, 1'b0, 0, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 8'hFF, 1'b1);
        idle(1'b1);

        // same-cycle alloc: alloc0 (6) older than alloc1 (0)
        step(1'b1, 1'b0, 1'b1, 6, 1'b1, 0, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 8'h41, 1'b1);
        idle(1'b1);

        // stalled slot holds 4 while older 7 becomes ready
        step(1'b1, 1'b0, 1'b1, 7, 1'b0, 0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b1, 4, 1'b0, 0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 8'h10, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 8'h90, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 8'h90, 1'b1);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 8'h80, 1'b1);
        idle(1'b1);

        // flush while slot accepted: no release, fresh age order afterwards
        step(1'b1, 1'b0, 1'b1, 5, 1'b0, 0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 8'h20, 1'b0);
        step(1'b1, 1'b1, 1'b1, 2, 1'b0, 0, 8'h20, 1'b1);
        step(1'b1, 1'b0, 1'b1, 3, 1'b0, 0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1, 1'b0, 0, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 8'h0A, 1'b1);
        idle(1'b1);

        // reset discards an occupied slot with no release
        step(1'b1, 1'b0, 1'b1, 2, 1'b0, 0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 8'h04, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 8'h04, 1'b1);
        idle(1'b1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            fl.delete();
            for (int k = 0; k < QSIZE; k++) if (!occ[k]) fl.push_back(k);
            a0v = 1'b0; a1v = 1'b0; a0i = 0; a1i = 0;
            if (fl.size() > 0 && ($urandom % 2) == 0) begin
                p = $urandom_range(0, fl.size() - 1);
                a0v = 1'b1; a0i = fl[p]; fl.delete(p);
            end
            if (fl.size() > 0 && ($urandom % 5) < 2) begin
                p = $urandom_range(0, fl.size() - 1);
                a1v = 1'b1; a1i = fl[p]; fl.delete(p);
            end
            rs   = ($urandom % 200) != 0;
            fl_i = ($urandom % 40) == 0;
            rdy  = QSIZE'($urandom);
            alu  = ($urandom % 4) != 0;
            step(rs, fl_i, a0v, a0i, a1v, a1i, rdy, alu);
        end

        for (int k = 0; k < 4; k++) idle(1'b1);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
